// File: rtl/vote3_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vote3_ctrl_pkg
// Shared definitions for the three-person voting front end:
//   - FSM state encoding (binary, 2 bits)
//   - majority3(): 2-of-3 majority over a {A,B,C} ballot vector
// Imported by vote3_ctrl. The verdict logic calls majority3() so that every
// user of the voting function resolves ballots the same way.
// -----------------------------------------------------------------------------
package vote3_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VOTE   = 2'd1,
    ST_RESULT = 2'd2
  } state_t;

  // Ballot bit order is {A,B,C}. A voter that never pressed counts as "no".
  function automatic logic majority3(input logic [2:0] ballot);
    return (ballot[2] & ballot[1]) |
           (ballot[1] & ballot[0]) |
           (ballot[2] & ballot[0]);
  endfunction

endpackage

// File: rtl/vote3_ctrl_key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Turns one raw, bounce-prone, active-low push-key into a clean debounced
// level and a single-cycle press strobe.
//
// Parameters:
//   DEB_CYCLES  stability time in clocks before the debounced level follows
//               the synchronized key (minimum 2)
//
// Ports:
//   CLK_50M    in   system clock
//   RST_N      in   asynchronous active-low reset
//   KEY_IN     in   raw key pin, active-low, asynchronous to CLK_50M
//   KEY_LEVEL  out  debounced key level (idle high)
//   KEY_PRESS  out  one-cycle registered strobe on a debounced 1->0 edge
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic CLK_50M,
  input  logic RST_N,
  input  logic KEY_IN,
  output logic KEY_LEVEL,
  output logic KEY_PRESS
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_meta;
  logic          sync_key;
  logic          level_q;
  logic          level_prev;
  logic          press_q;
  logic [CW-1:0] stable_cnt;

  // Synchronizer and debouncer idle high so that a reset never looks like
  // a press once released.
  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      sync_meta  <= 1'b1;
      sync_key   <= 1'b1;
      level_q    <= 1'b1;
      level_prev <= 1'b1;
      press_q    <= 1'b0;
      stable_cnt <= '0;
    end else begin
      sync_meta  <= KEY_IN;
      sync_key   <= sync_meta;
      level_prev <= level_q;
      // Only a debounced fall produces a strobe; releases are silent.
      press_q    <= level_prev & ~level_q;

      if (sync_key != level_q) begin
        if (stable_cnt == CNT_LAST) begin
          level_q    <= sync_key;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CW'(1);
        end
      end else begin
        // Any return to the current level restarts the stability count,
        // which is what rejects short glitches.
        stable_cnt <= '0;
      end
    end
  end

  assign KEY_LEVEL = level_q;
  assign KEY_PRESS = press_q;

endmodule

// File: rtl/vote3_ctrl.sv
// -----------------------------------------------------------------------------
// vote3_ctrl
// Sequential front end of the three-person voting function. Debounces the
// START key and three voter keys, opens a timed voting window on START,
// latches one sticky ballot per voter and, when the window closes (timeout
// or all three voted), resolves the 2-of-3 majority and holds it on LEDs.
//
// Parameters:
//   DEB_CYCLES  debounce stability time in clocks (minimum 2)
//   WIN_CYCLES  voting window length in clocks (minimum 2)
//
// Ports:
//   CLK_50M    in   system clock (only clock)
//   RST_N      in   asynchronous active-low reset
//   KEY_START  in   raw start key, active-low
//   KEY_A/B/C  in   raw voter keys, active-low
//   LED_VOTE   out  latched ballots {A,B,C}, 1 = yes
//   LED_PASS   out  verdict: two or more yes votes
//   LED_FAIL   out  verdict: fewer than two yes votes
//   BUSY       out  high while the voting window is open
//   DONE       out  one-cycle strobe when a verdict is produced
//
// State table:
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | after reset, no session yet; waits for START
//   ST_VOTE   | window open, counter running, ballots being latched
//   ST_RESULT | verdict held on LEDs; START begins a new session
// -----------------------------------------------------------------------------
module vote3_ctrl
  import vote3_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int WIN_CYCLES = 500_000_000
) (
  input  logic       CLK_50M,
  input  logic       RST_N,
  input  logic       KEY_START,
  input  logic       KEY_A,
  input  logic       KEY_B,
  input  logic       KEY_C,
  output logic [2:0] LED_VOTE,
  output logic       LED_PASS,
  output logic       LED_FAIL,
  output logic       BUSY,
  output logic       DONE
);

  localparam int WW = (WIN_CYCLES > 1) ? $clog2(WIN_CYCLES) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'(WIN_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Key path
  // ---------------------------------------------------------------------------
  logic [3:0] key_level;
  logic       start_press;
  logic [2:0] voter_press;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_start (
    .CLK_50M  (CLK_50M),
    .RST_N    (RST_N),
    .KEY_IN   (KEY_START),
    .KEY_LEVEL(key_level[3]),
    .KEY_PRESS(start_press)
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_a (
    .CLK_50M  (CLK_50M),
    .RST_N    (RST_N),
    .KEY_IN   (KEY_A),
    .KEY_LEVEL(key_level[2]),
    .KEY_PRESS(voter_press[2])
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_b (
    .CLK_50M  (CLK_50M),
    .RST_N    (RST_N),
    .KEY_IN   (KEY_B),
    .KEY_LEVEL(key_level[1]),
    .KEY_PRESS(voter_press[1])
  );

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_c (
    .CLK_50M  (CLK_50M),
    .RST_N    (RST_N),
    .KEY_IN   (KEY_C),
    .KEY_LEVEL(key_level[0]),
    .KEY_PRESS(voter_press[0])
  );

  // ---------------------------------------------------------------------------
  // FSM, window counter, ballot register and verdict
  // ---------------------------------------------------------------------------
  state_t        state, state_n;
  logic [WW-1:0] win_cnt, win_cnt_n;
  logic [2:0]    vote_q, vote_n;
  logic          pass_q, pass_n;
  logic          fail_q, fail_n;
  logic          busy_q, busy_n;
  logic          done_q, done_n;
  logic [2:0]    ballot;

  always_ff @(posedge CLK_50M or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      win_cnt <= '0;
      vote_q  <= 3'b000;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      win_cnt <= win_cnt_n;
      vote_q  <= vote_n;
      pass_q  <= pass_n;
      fail_q  <= fail_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Ballots including this cycle's strobes: a press landing on the expiry
  // cycle is folded in before the verdict is taken.
  assign ballot = vote_q | voter_press;

  always_comb begin
    state_n   = state;
    win_cnt_n = win_cnt;
    vote_n    = vote_q;
    pass_n    = pass_q;
    fail_n    = fail_q;
    busy_n    = busy_q;
    done_n    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_press) begin
          state_n   = ST_VOTE;
          win_cnt_n = '0;
          vote_n    = 3'b000;
          pass_n    = 1'b0;
          fail_n    = 1'b0;
          busy_n    = 1'b1;
        end
      end

      ST_VOTE: begin
        win_cnt_n = win_cnt + WW'(1);
        vote_n    = ballot;
        // All-voted exit looks at the registered ballot, so it lands one
        // edge after the third bit sets, matching the timeout latency.
        if ((win_cnt == WIN_LAST) || (vote_q == 3'b111)) begin
          state_n = ST_RESULT;
          pass_n  = majority3(ballot);
          fail_n  = ~majority3(ballot);
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end

      ST_RESULT: begin
        if (start_press) begin
          state_n   = ST_VOTE;
          win_cnt_n = '0;
          vote_n    = 3'b000;
          pass_n    = 1'b0;
          fail_n    = 1'b0;
          busy_n    = 1'b1;
        end
      end

      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign LED_VOTE = vote_q;
  assign LED_PASS = pass_q;
  assign LED_FAIL = fail_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;

endmodule

// File: tb/tb_vote3_ctrl.sv
module tb_vote3_ctrl;
  import vote3_ctrl_pkg::*;

  localparam int DEB = 4;
  localparam int WIN = 100;

  logic       CLK_50M = 1'b0;
  logic       RST_N = 1'b0;
  logic       KEY_START = 1'b1;
  logic       KEY_A = 1'b1;
  logic       KEY_B = 1'b1;
  logic       KEY_C = 1'b1;
  logic [2:0] LED_VOTE;
  logic       LED_PASS;
  logic       LED_FAIL;
  logic       BUSY;
  logic       DONE;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vote3_ctrl #(.DEB_CYCLES(DEB), .WIN_CYCLES(WIN)) dut (
    .CLK_50M  (CLK_50M),
    .RST_N    (RST_N),
    .KEY_START(KEY_START),
    .KEY_A    (KEY_A),
    .KEY_B    (KEY_B),
    .KEY_C    (KEY_C),
    .LED_VOTE (LED_VOTE),
    .LED_PASS (LED_PASS),
    .LED_FAIL (LED_FAIL),
    .BUSY     (BUSY),
    .DONE     (DONE)
  );

  always #10 CLK_50M = ~CLK_50M;
  always @(posedge CLK_50M) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge CLK_50M);
  endtask

  task automatic set_key(input int which, input logic v);
    case (which)
      0: KEY_A = v;
      1: KEY_B = v;
      2: KEY_C = v;
      default: KEY_START = v;
    endcase
  endtask

  task automatic press_key(input int which, input int hold);
    set_key(which, 1'b0);
    tick(hold);
    set_key(which, 1'b1);
    tick(10);
  endtask

  // Presses START and returns the edge count at which BUSY was first seen.
  task automatic start_session(output int s1);
    s1 = -1;
    set_key(3, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (BUSY === 1'b1) begin
        s1 = cyc;
        break;
      end
    end
    checks++;
    if (s1 < 0) begin
      errors++;
      $display("FAIL start_session: BUSY=%b after 15 cycles, required 1", BUSY);
    end
    set_key(3, 1'b1);
    tick(10);
  endtask

  task automatic wait_until(input int target);
    for (int g = 0; g < 400 && cyc < target; g++) tick(1);
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    tick(3);
    checks++; if (LED_VOTE !== 3'b000) begin errors++; $display("FAIL reset_vote: got %b want 000", LED_VOTE); end
    checks++; if (LED_PASS !== 1'b0) begin errors++; $display("FAIL reset_pass: got %b want 0", LED_PASS); end
    checks++; if (LED_FAIL !== 1'b0) begin errors++; $display("FAIL reset_fail: got %b want 0", LED_FAIL); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", DONE); end
    RST_N = 1'b1;
    tick(2);
  endtask

  task automatic test_reset_mid_vote;
    int s1;
    start_session(s1);
    press_key(0, 10);
    checks++; if (LED_VOTE !== 3'b100) begin errors++; $display("FAIL midvote_a: got %b want 100", LED_VOTE); end
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL midvote_busy: got %b want 1", BUSY); end
    tick(3);
    #5 RST_N = 1'b0;
    #1;
    checks++; if (LED_VOTE !== 3'b000) begin errors++; $display("FAIL async_rst_vote: got %b want 000", LED_VOTE); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL async_rst_busy: got %b want 0", BUSY); end
    checks++; if ({LED_PASS, LED_FAIL, DONE} !== 3'b000) begin errors++; $display("FAIL async_rst_verdict: got %b want 000", {LED_PASS, LED_FAIL, DONE}); end
    checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL async_rst_state: got %0d want 0", dut.state); end
    @(negedge CLK_50M);
    RST_N = 1'b1;
    tick(2);
    press_key(0, 10);
    checks++; if (LED_VOTE !== 3'b000) begin errors++; $display("FAIL idle_press_ignored: got %b want 000", LED_VOTE); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", BUSY); end
  endtask

  task automatic test_timed_window;
    int s1;
    start_session(s1);
    press_key(0, 10);
    press_key(2, 10);
    wait_until(s1 + 99);
    checks++; if (BUSY !== 1'b1 || DONE !== 1'b0) begin errors++; $display("FAIL window_99: busy=%b done=%b want busy=1 done=0", BUSY, DONE); end
    tick(1);
    checks++; if (cyc != s1 + 100) begin errors++; $display("FAIL window_cycle: got %0d want %0d", cyc - s1, 100); end
    checks++; if (LED_VOTE !== 3'b101) begin errors++; $display("FAIL window_vote: got %b want 101", LED_VOTE); end
    checks++; if (LED_PASS !== 1'b1 || LED_FAIL !== 1'b0) begin errors++; $display("FAIL window_verdict: pass=%b fail=%b want 1/0", LED_PASS, LED_FAIL); end
    checks++; if (DONE !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL window_done: done=%b busy=%b want 1/0", DONE, BUSY); end
    tick(1);
    checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL done_width: got %b want 0", DONE); end
    checks++; if (LED_PASS !== 1'b1 || LED_VOTE !== 3'b101) begin errors++; $display("FAIL result_hold: pass=%b vote=%b want 1/101", LED_PASS, LED_VOTE); end
  endtask

  task automatic test_bounce;
    int s1;
    int strobes;
    start_session(s1);
    checks++; if (LED_VOTE !== 3'b000 || LED_PASS !== 1'b0) begin errors++; $display("FAIL new_session_clear: vote=%b pass=%b want 000/0", LED_VOTE, LED_PASS); end
    strobes = 0;
    KEY_B = 1'b0;
    tick(3);
    KEY_B = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (dut.u_key_b.KEY_PRESS === 1'b1) strobes++;
    end
    checks++; if (strobes != 0) begin errors++; $display("FAIL bounce_strobe: got %0d want 0", strobes); end
    wait_until(s1 + 100);
    checks++; if (LED_VOTE !== 3'b000) begin errors++; $display("FAIL bounce_vote: got %b want 000", LED_VOTE); end
    checks++; if (LED_FAIL !== 1'b1 || LED_PASS !== 1'b0 || DONE !== 1'b1) begin errors++; $display("FAIL bounce_verdict: fail=%b pass=%b done=%b want 1/0/1", LED_FAIL, LED_PASS, DONE); end
  endtask

  task automatic test_early_exit;
    int s1;
    int vote_idx;
    int done_idx;
    int done_cnt;
    int done_cyc;
    logic pass_at_done;
    logic busy_at_done;
    start_session(s1);
    vote_idx = -1; done_idx = -1; done_cnt = 0; done_cyc = 0;
    pass_at_done = 1'b0; busy_at_done = 1'b1;
    for (int j = 0; j < 45; j++) begin
      KEY_A = !(j < 10);
      KEY_B = !(j >= 10 && j < 20);
      KEY_C = !(j >= 20 && j < 30);
      tick(1);
      if (LED_VOTE === 3'b111 && vote_idx < 0) vote_idx = j + 1;
      if (DONE === 1'b1) begin
        done_cnt++;
        if (done_idx < 0) begin
          done_idx = j + 1;
          done_cyc = cyc;
          pass_at_done = LED_PASS;
          busy_at_done = BUSY;
        end
      end
    end
    checks++; if (vote_idx != 28) begin errors++; $display("FAIL early_third_bit: got %0d want 28", vote_idx); end
    checks++; if (done_idx != 29) begin errors++; $display("FAIL early_done_time: got %0d want 29", done_idx); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL early_done_count: got %0d want 1", done_cnt); end
    checks++; if (pass_at_done !== 1'b1 || busy_at_done !== 1'b0) begin errors++; $display("FAIL early_verdict: pass=%b busy=%b want 1/0", pass_at_done, busy_at_done); end
    checks++; if (done_cyc - s1 >= 99) begin errors++; $display("FAIL early_before_timeout: got %0d want < 99", done_cyc - s1); end
  endtask

  task automatic test_repeat_session;
    int s1;
    int busy_low;
    start_session(s1);
    press_key(1, 10);
    press_key(1, 10);
    checks++; if (LED_VOTE !== 3'b010) begin errors++; $display("FAIL repeat_vote: got %b want 010", LED_VOTE); end
    busy_low = 0;
    KEY_START = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) KEY_START = 1'b1;
      tick(1);
      if (BUSY !== 1'b1) busy_low++;
    end
    checks++; if (busy_low != 0) begin errors++; $display("FAIL start_in_vote: busy low %0d cycles want 0", busy_low); end
    checks++; if (LED_VOTE !== 3'b010) begin errors++; $display("FAIL start_in_vote_vote: got %b want 010", LED_VOTE); end
    wait_until(s1 + 100);
    checks++; if (LED_VOTE !== 3'b010 || LED_FAIL !== 1'b1 || LED_PASS !== 1'b0) begin errors++; $display("FAIL repeat_verdict: vote=%b fail=%b pass=%b want 010/1/0", LED_VOTE, LED_FAIL, LED_PASS); end
    tick(5);
    KEY_START = 1'b0;
    tick(7);
    checks++; if (dut.u_key_start.KEY_PRESS !== 1'b1 || BUSY !== 1'b0) begin errors++; $display("FAIL result_start_strobe: strobe=%b busy=%b want 1/0", dut.u_key_start.KEY_PRESS, BUSY); end
    tick(1);
    checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL result_start_busy: got %b want 1", BUSY); end
    checks++; if (LED_VOTE !== 3'b000 || LED_FAIL !== 1'b0 || LED_PASS !== 1'b0) begin errors++; $display("FAIL result_start_clear: vote=%b fail=%b pass=%b want 000/0/0", LED_VOTE, LED_FAIL, LED_PASS); end
    KEY_START = 1'b1;
    tick(10);
  endtask

  task automatic test_strobe_latency;
    int strobes;
    int first;
    strobes = 0;
    first = -1;
    for (int i = 0; i < 40; i++) begin
      KEY_A = (i < 20) ? 1'b0 : 1'b1;
      tick(1);
      if (dut.u_key_a.KEY_PRESS === 1'b1) begin
        strobes++;
        if (first < 0) first = i + 1;
      end
    end
    checks++; if (strobes != 1) begin errors++; $display("FAIL strobe_count: got %0d want 1", strobes); end
    checks++; if (first != DEB + 3) begin errors++; $display("FAIL strobe_latency: got %0d want %0d", first, DEB + 3); end
    checks++; if (LED_VOTE !== 3'b100) begin errors++; $display("FAIL strobe_vote: got %b want 100", LED_VOTE); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_vote();
    test_timed_window();
    test_bounce();
    test_early_exit();
    test_repeat_session();
    test_strobe_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
